// File: rtl/lfo_pkg.sv
// Shared types and the rate-increment helper for the multi-shape LFO.
// lfo_inc is evaluated at elaboration to build the constant rate table.
package lfo_pkg;

  typedef enum logic [1:0] {
    LFO_TRI  = 2'd0,
    LFO_SAW  = 2'd1,
    LFO_SQR  = 2'd2,
    LFO_RAMP = 2'd3
  } lfo_mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } lfo_state_t;

  // round((k+1) * 2^phase_w / tick_hz), rounding half up
  function automatic longint lfo_inc(input int k, input int phase_w, input int tick_hz);
    longint num;
    num = longint'(k + 1) << phase_w;
    return (2 * num + longint'(tick_hz)) / (2 * longint'(tick_hz));
  endfunction

endpackage

// File: rtl/lfo_shaper.sv
// Combinational phase-to-shape mapping. Only the top OUT_W phase bits matter,
// so the caller passes just that slice.
module lfo_shaper
  import lfo_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic [OUT_W-1:0] i_phase_hi,
  input  lfo_mode_t        i_mode,
  output logic [OUT_W-2:0] o_u
);

  localparam int S = OUT_W - 1;

  logic w_msb;
  assign w_msb = i_phase_hi[S];

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    o_u = '0;
    case (i_mode)
      LFO_TRI:  o_u = w_msb ? ~i_phase_hi[S-1:0] : i_phase_hi[S-1:0];
      LFO_SAW:  o_u = i_phase_hi[S:1];
      LFO_SQR:  o_u = {S{w_msb}};
      LFO_RAMP: o_u = ~i_phase_hi[S:1];
      default:  o_u = '0;
    endcase
  end

endmodule

// File: rtl/lfo_multi_generator.sv
// Low-frequency oscillator: phase accumulator on a sample strobe, four shapes,
// downward swing from a rest level, retune at wrap and optional soft stop.
module lfo_multi_generator
  import lfo_pkg::*;
#(
  parameter int OUT_W      = 16,
  parameter int PHASE_W    = 24,
  parameter int FREQ_W     = 3,
  parameter int TICK_HZ    = 32000,
  parameter int REST_LEVEL = 28672,
  parameter int SOFT_STOP  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_tick,
  input  logic                    i_start,
  input  logic [FREQ_W-1:0]       i_freq,
  input  logic [1:0]              i_mode,
  input  logic [3:0]              i_depth,
  output logic signed [OUT_W-1:0] o_wave,
  output logic                    o_valid,
  output logic                    o_busy
);

  localparam int                      S       = OUT_W - 1;
  localparam int                      N_RATES = 2 ** FREQ_W;
  localparam logic signed [OUT_W-1:0] REST    = OUT_W'(REST_LEVEL);
  localparam bit                      SOFT    = (SOFT_STOP != 0);

  logic [PHASE_W-1:0] w_inc_tab [N_RATES];
  for (genvar g = 0; g < N_RATES; g++) begin : g_inc_tab
    assign w_inc_tab[g] = PHASE_W'(lfo_inc(g, PHASE_W, TICK_HZ));
  end

  lfo_state_t                r_state;
  lfo_state_t                w_state_next;
  logic [PHASE_W-1:0]        r_phase;
  logic [PHASE_W-1:0]        r_inc;
  logic [3:0]                r_depth;
  lfo_mode_t                 r_mode;
  logic signed [OUT_W-1:0]   r_wave;
  logic                      r_valid;

  logic [PHASE_W:0]          w_sum;
  logic                      w_run_like;
  logic                      w_hard_stop;
  logic                      w_advance;
  logic                      w_wrap;
  logic                      w_retune;
  logic                      w_drain_end;
  logic                      w_latch;
  logic [3:0]                w_depth_eff;
  logic [S-1:0]              w_u;
  logic [S-1:0]              w_dev;
  logic signed [OUT_W-1:0]   w_wave_next;

  assign w_sum = {1'b0, r_phase} + {1'b0, r_inc};

  // NOTE: async reset with non-blocking updates; state only ever changes via <= here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // A DRAIN cycle with i_start high behaves exactly like RUN, including retune.
  always_comb begin
    w_run_like  = (r_state == S_RUN) || ((r_state == S_DRAIN) && i_start);
    w_hard_stop = (r_state == S_RUN) && !i_start && !SOFT;
    w_advance   = i_tick && (r_state != S_IDLE) && !w_hard_stop;
    w_wrap      = w_advance && w_sum[PHASE_W];
    w_retune    = w_wrap && w_run_like;
    w_drain_end = w_wrap && !w_run_like;
    w_latch     = (r_state == S_IDLE) && i_start;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_RUN;
      S_RUN:   if (!i_start) w_state_next = SOFT ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (i_start)          w_state_next = S_RUN;
        else if (w_drain_end) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  lfo_shaper #(.OUT_W(OUT_W)) u_shaper (
    .i_phase_hi (w_sum[PHASE_W-1 -: OUT_W]),
    .i_mode     (r_mode),
    .o_u        (w_u)
  );

  // The wrap sample opens a new period, so it already uses the re-sampled depth.
  assign w_depth_eff = w_retune ? i_depth : r_depth;
  assign w_dev       = w_u >> w_depth_eff;
  assign w_wave_next = REST - $signed({1'b0, w_dev});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_inc   <= '0;
      r_depth <= '0;
      r_mode  <= LFO_TRI;
      r_wave  <= REST;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_latch) begin
        r_inc   <= w_inc_tab[i_freq];
        r_mode  <= lfo_mode_t'(i_mode);
        r_depth <= i_depth;
      end
      if (w_hard_stop) begin
        r_phase <= '0;
        r_wave  <= REST;
      end else if (w_drain_end) begin
        r_phase <= '0;
        r_wave  <= REST;
        r_valid <= 1'b1;
      end else if (w_advance) begin
        r_phase <= w_sum[PHASE_W-1:0];
        r_wave  <= w_wave_next;
        r_valid <= 1'b1;
        if (w_retune) begin
          r_inc   <= w_inc_tab[i_freq];
          r_depth <= i_depth;
        end
      end
    end
  end

  assign o_wave  = r_wave;
  assign o_valid = r_valid;
  assign o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_lfo_multi_generator.sv
// Randomised bench for lfo_multi_generator: arithmetic reference model feeds a
// scoreboard queue, a negedge monitor pops and compares each o_valid sample.
`timescale 1ns/1ps
module tb_lfo_multi_generator;

  localparam longint REST  = 28672;
  localparam longint PMOD  = 64'd1 << 24;
  localparam longint HALF  = 64'd1 << 23;

  typedef struct {
    longint wave;
    longint due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick, start;
  logic [2:0]        freq;
  logic [1:0]        mode;
  logic [3:0]        depth;
  logic signed [15:0] wave;
  logic              valid, busy;

  logic              h_tick, h_start;
  logic [2:0]        h_freq;
  logic [1:0]        h_mode;
  logic [3:0]        h_depth;
  logic signed [15:0] h_wave;
  logic              h_valid, h_busy;

  always #5 clk = ~clk;

  lfo_multi_generator #(.SOFT_STOP(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_start(start),
    .i_freq(freq), .i_mode(mode), .i_depth(depth),
    .o_wave(wave), .o_valid(valid), .o_busy(busy)
  );

  lfo_multi_generator #(.SOFT_STOP(0)) dut_hard (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(h_tick), .i_start(h_start),
    .i_freq(h_freq), .i_mode(h_mode), .i_depth(h_depth),
    .o_wave(h_wave), .o_valid(h_valid), .o_busy(h_busy)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  exp_t   sb[$];

  // reference model state
  bit     m_busy, m_drain;
  longint m_phase, m_inc, m_last;
  int     m_mode, m_depth;
  bit     trk;
  longint exp_min, exp_max, obs_min, obs_max;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint inc_of(input int k);
    return ((k + 1) * 2 * PMOD + 32000) / 64000;
  endfunction

  function automatic longint wave_of(input longint ph, input int md, input int dp);
    longint u;
    case (md)
      0:       u = (ph < HALF) ? ph / 256 : 32767 - (ph - HALF) / 256;
      1:       u = ph / 512;
      2:       u = (ph >= HALF) ? 32767 : 0;
      default: u = 32767 - ph / 512;
    endcase
    return REST - u / (64'd1 << dp);
  endfunction

  task automatic push(input longint w);
    exp_t e;
    e.wave = w;
    e.due  = cyc + 1;
    sb.push_back(e);
    m_last = w;
    if (trk) begin
      if (w < exp_min) exp_min = w;
      if (w > exp_max) exp_max = w;
    end
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    longint nxt;
    bit     carry;
    if (!rst_n) return;
    if (!m_busy) begin
      if (start) begin
        m_busy  = 1'b1;
        m_drain = 1'b0;
        m_inc   = inc_of(int'(freq));
        m_mode  = int'(mode);
        m_depth = int'(depth);
      end
    end else begin
      if (tick) begin
        nxt   = m_phase + m_inc;
        carry = (nxt >= PMOD);
        nxt   = nxt % PMOD;
        if (carry && m_drain && !start) begin
          m_phase = 0;
          push(REST);
          m_busy  = 1'b0;
        end else begin
          if (carry) begin
            m_inc   = inc_of(int'(freq));
            m_depth = int'(depth);
          end
          m_phase = nxt;
          push(wave_of(m_phase, m_mode, m_depth));
        end
      end
      if (m_busy) m_drain = !start;
    end
  endtask

  task automatic drive(input logic t);
    tick = t;
    model_step();
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic tick_n(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b1);
      repeat ($urandom_range(max_gap)) drive(1'b0);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_phase = 0; m_inc = 0; m_mode = 0; m_depth = 0;
    m_last = REST;
    sb.delete();
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        check("valid_missing_cycle", cyc, e.due);
      end
      if (valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid: got wave %0d, expected no output (t=%0t)", wave, $time);
        end else begin
          e = sb.pop_front();
          check("wave", wave, e.wave);
          check("valid_cycle", cyc, e.due);
        end
        if (trk) begin
          if (wave < obs_min) obs_min = wave;
          if (wave > obs_max) obs_max = wave;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; tick = 0; start = 0; freq = 0; mode = 0; depth = 0;
    h_tick = 0; h_start = 0; h_freq = 3'd7; h_mode = 2'd0; h_depth = 4'd0;
    trk = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wave", wave, REST);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // start TRI freq7 depth0 with a tick in the same cycle: that tick is ignored
    start = 1; freq = 3'd7; mode = 2'd0; depth = 4'd0;
    drive(1'b1);
    check("start_busy", busy, 1);
    drive(1'b1);
    check("first_tick_wave", wave, 28656);
    check("first_tick_valid", valid, 1);
    exp_min = REST; exp_max = -65536; obs_min = REST; obs_max = -65536;
    trk = 1;
    tick_n(3999, 1);
    drive(1'b0);
    trk = 0;
    check("sweep_valley", obs_min, exp_min);
    check("sweep_peak", obs_max, exp_max);
    check("tri_valley_value", obs_min, -4093);

    // mid-period mode/depth changes: mode ignored, depth waits for the wrap
    mode  = 2'($urandom_range(3));
    depth = 4'($urandom_range(15));
    tick_n(300, 1);
    drive(1'b0);
    drive(1'b0);
    check("hold_wave", wave, m_last);
    check("hold_valid", valid, 0);

    // soft stop, resume during drain, then let the period finish
    start = 0;
    tick_n(200, 1);
    check("drain_busy", busy, 1);
    start = 1;
    tick_n(50, 1);
    start = 0;
    k = 0;
    while (busy && k < 6000) begin
      drive(1'b1);
      drive(1'b0);
      k++;
    end
    check("drain_done_busy", busy, 0);
    check("drain_done_model_busy", busy, m_busy);
    check("drain_done_wave", wave, REST);
    drive(1'b1);
    drive(1'b0);

    // retune at wrap: freq 7 -> 0 mid-period takes effect after the carry
    start = 1; freq = 3'd7; mode = 2'd0; depth = 4'd2;
    drive(1'b0);
    tick_n(100, 1);
    freq = 3'd0; mode = 2'd3; depth = 4'd5;
    tick_n(3950, 1);
    tick_n(20, 1);
    drive(1'b0);
    check("retune_busy", busy, 1);

    // async reset between ticks forces reset values immediately
    rst_n = 1'b0;
    #1;
    check("midrun_rst_wave", wave, REST);
    check("midrun_rst_valid", valid, 0);
    check("midrun_rst_busy", busy, 0);
    do_reset();

    // slowest rate: 16000 ticks land just below the half-period point
    start = 1; freq = 3'd0; mode = 2'd0; depth = 4'd0;
    drive(1'b0);
    tick_n(16000, 0);
    drive(1'b0);
    check("slow_16000_wave", wave, -4078);
    do_reset();

    // square wave with depth 3 across the half-period edge
    start = 1; freq = 3'd7; mode = 2'd2; depth = 4'd3;
    drive(1'b0);
    tick_n(2000, 0);
    check("sqr_low_half", wave, 28672);
    tick_n(1, 0);
    check("sqr_high_half", wave, 24577);
    tick_n(20, 1);
    drive(1'b0);
    do_reset();

    // immediate-stop build
    h_start = 1;
    drive(1'b0);
    h_tick = 1; drive(1'b0); h_tick = 0;
    check("hard_tick_wave", h_wave, 28656);
    check("hard_tick_valid", h_valid, 1);
    check("hard_busy", h_busy, 1);
    drive(1'b0);
    check("hard_valid_pulse", h_valid, 0);
    h_tick = 1; h_start = 0; drive(1'b0); h_tick = 0;
    check("hard_stop_wave", h_wave, REST);
    check("hard_stop_valid", h_valid, 0);
    check("hard_stop_busy", h_busy, 0);
    h_start = 1;
    drive(1'b0);
    h_tick = 1; drive(1'b0); h_tick = 0;
    check("hard_restart_wave", h_wave, 28656);
    h_start = 0;
    drive(1'b0);

    drive(1'b0);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
